// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined control path: control bundle, opcodes, ALU/imm/result codes
// and the small hazard/forwarding helpers used by pipe_control.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010, ALU_OR   = 4'b0011,
    ALU_XOR    = 4'b0100, ALU_SLT  = 4'b0101, ALU_SLTU = 4'b0110, ALU_SRL  = 4'b0111,
    ALU_SLL    = 4'b1000, ALU_SRA  = 4'b1001, ALU_PASSB = 4'b1010, ALU_JALR = 4'b1011,
    ALU_JAL    = 4'b1100, ALU_MEMADD = 4'b1111
  } alu_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100
  } imm_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10
  } res_t;

  typedef struct packed {
    logic             valid;
    logic             regWrite;
    logic             memWrite;
    res_t             resultSrc;
    alu_t             aluCtrl;
    logic             aluSrcA;
    logic             aluSrc;
    imm_t             immSrc;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic [1:0]       memSize;
    logic             memUnsigned;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             useRs1;
    logic             useRs2;
  } ctrl_t;

  // Shared by OP and OP-IMM; alt is bit 30 already qualified by the caller.
  function automatic alu_t alu_op(logic [2:0] f3, logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic reads_reg(ctrl_t id, logic [REG_W-1:0] r);
    return (r != '0) && ((id.useRs1 && id.rs1 == r) || (id.useRs2 && id.rs2 == r));
  endfunction

  function automatic logic [1:0] fwd_sel(logic [REG_W-1:0] src, ctrl_t mem, ctrl_t wb);
    if (mem.regWrite && mem.rd != '0 && mem.rd == src) return 2'b10;
    if (wb.regWrite && wb.rd != '0 && wb.rd == src)    return 2'b01;
    return 2'b00;
  endfunction

endpackage

// File: rtl/pipe_decode.sv
// Combinational RV32I control decoder: instruction word -> ctrl_t plus illegal flag.
// Illegal encodings decode to an all-zero bubble.
module pipe_decode
  import pipe_ctrl_pkg::*;
#(
  parameter bit HALF_EN    = 1'b1,
  parameter int REG_ADDR_W = 5
) (
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic        o_illegal
);

  localparam logic [REG_W-1:0] RMASK = REG_W'((1 << REG_ADDR_W) - 1);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_ld_ok, w_st_ok, w_ill, w_unused;
  ctrl_t      w_c;

  assign w_op     = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_unused = ^{i_instr[31], i_instr[29:25]};

  assign w_ld_ok = (w_f3 == 3'b000) || (w_f3 == 3'b010) ||
                   (HALF_EN && (w_f3 == 3'b001 || w_f3 == 3'b100 || w_f3 == 3'b101));
  assign w_st_ok = (w_f3 == 3'b000) || (w_f3 == 3'b010) || (HALF_EN && w_f3 == 3'b001);

  always_comb begin
    w_c   = '0;
    w_ill = 1'b0;
    case (w_op)
      OP_OP: begin
        w_c.regWrite = 1'b1; w_c.useRs1 = 1'b1; w_c.useRs2 = 1'b1;
        w_c.aluCtrl  = alu_op(w_f3, i_instr[30]);
      end
      OP_IMM: begin
        // addi has no subtract form, so bit 30 only matters for the shifts
        w_c.regWrite = 1'b1; w_c.useRs1 = 1'b1; w_c.aluSrc = 1'b1; w_c.immSrc = IMM_I;
        w_c.aluCtrl  = alu_op(w_f3, (w_f3 == 3'b101) && i_instr[30]);
      end
      OP_LOAD: begin
        w_c.regWrite = 1'b1; w_c.resultSrc = RES_MEM; w_c.useRs1 = 1'b1;
        w_c.aluSrc   = 1'b1; w_c.immSrc = IMM_I; w_c.aluCtrl = ALU_MEMADD;
        w_c.memSize  = w_f3[1:0]; w_c.memUnsigned = w_f3[2];
        w_ill        = !w_ld_ok;
      end
      OP_STORE: begin
        w_c.memWrite = 1'b1; w_c.useRs1 = 1'b1; w_c.useRs2 = 1'b1;
        w_c.aluSrc   = 1'b1; w_c.immSrc = IMM_S; w_c.aluCtrl = ALU_MEMADD;
        w_c.memSize  = w_f3[1:0];
        w_ill        = !w_st_ok;
      end
      OP_BRANCH: begin
        w_c.branch = 1'b1; w_c.useRs1 = 1'b1; w_c.useRs2 = 1'b1; w_c.immSrc = IMM_B;
        w_c.aluCtrl = w_f3[2] ? (w_f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      end
      OP_JAL: begin
        w_c.jal = 1'b1; w_c.regWrite = 1'b1; w_c.resultSrc = RES_PC4;
        w_c.aluSrcA = 1'b1; w_c.aluSrc = 1'b1; w_c.immSrc = IMM_J; w_c.aluCtrl = ALU_JAL;
      end
      OP_JALR: begin
        w_c.jalr = 1'b1; w_c.regWrite = 1'b1; w_c.resultSrc = RES_PC4; w_c.useRs1 = 1'b1;
        w_c.aluSrc = 1'b1; w_c.immSrc = IMM_I; w_c.aluCtrl = ALU_JALR;
      end
      OP_LUI: begin
        w_c.regWrite = 1'b1; w_c.aluSrc = 1'b1; w_c.immSrc = IMM_U; w_c.aluCtrl = ALU_PASSB;
      end
      OP_AUIPC: begin
        w_c.regWrite = 1'b1; w_c.aluSrcA = 1'b1; w_c.aluSrc = 1'b1;
        w_c.immSrc   = IMM_U; w_c.aluCtrl = ALU_ADD;
      end
      default: w_ill = 1'b1;
    endcase
    // Register fields are zeroed when unused so hazard/forward compares need no extra gating
    w_c.rd    = w_c.regWrite ? (i_instr[11:7]  & RMASK) : '0;
    w_c.rs1   = w_c.useRs1   ? (i_instr[19:15] & RMASK) : '0;
    w_c.rs2   = w_c.useRs2   ? (i_instr[24:20] & RMASK) : '0;
    w_c.valid = 1'b1;
    if (w_ill) w_c = '0;
  end

  assign o_ctrl    = w_c;
  assign o_illegal = w_ill;

endmodule

// File: rtl/pipe_control.sv
// ID decode plus ID->EX->MEM->WB control pipeline with load-use/RAW stall,
// EX operand forwarding select, flush and external hold.
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter bit HALF_EN    = 1'b1,
  parameter bit FWD_EN     = 1'b1,
  parameter int REG_ADDR_W = 5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        stall_o,
  output ctrl_t       ex_ctrl_o,
  output ctrl_t       mem_ctrl_o,
  output ctrl_t       wb_ctrl_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        illegal_o
);

  ctrl_t w_dec;
  logic  w_dec_ill;
  ctrl_t r_ex, r_mem, r_wb;
  logic  r_illegal;
  logic  w_id_live, w_load_use, w_raw, w_hazard;

  pipe_decode #(.HALF_EN(HALF_EN), .REG_ADDR_W(REG_ADDR_W)) u_decode (
    .i_instr   (instr_i),
    .o_ctrl    (w_dec),
    .o_illegal (w_dec_ill)
  );

  assign w_id_live  = instr_valid_i && w_dec.valid;
  assign w_load_use = w_id_live && r_ex.valid && (r_ex.resultSrc == RES_MEM) &&
                      reads_reg(w_dec, r_ex.rd);
  // Without forwarding any in-flight writer in EX or MEM must drain first; WB is covered
  // by the write-before-read regfile.
  assign w_raw      = w_id_live && ((r_ex.regWrite  && reads_reg(w_dec, r_ex.rd)) ||
                                    (r_mem.regWrite && reads_reg(w_dec, r_mem.rd)));
  assign w_hazard   = w_load_use || (!FWD_EN && w_raw);
  assign stall_o    = w_hazard && !flush_i;

  assign fwd_a_o = FWD_EN ? fwd_sel(r_ex.rs1, r_mem, r_wb) : 2'b00;
  assign fwd_b_o = FWD_EN ? fwd_sel(r_ex.rs2, r_mem, r_wb) : 2'b00;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ex      <= '0;
      r_mem     <= '0;
      r_wb      <= '0;
      r_illegal <= 1'b0;
    end else if (hold_i) begin
      r_illegal <= 1'b0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (flush_i || w_hazard) r_ex <= '0;
      else                     r_ex <= instr_valid_i ? w_dec : '0;
      r_illegal <= !flush_i && !w_hazard && instr_valid_i && w_dec_ill;
    end
  end

  assign ex_ctrl_o  = r_ex;
  assign mem_ctrl_o = r_mem;
  assign wb_ctrl_o  = r_wb;
  assign illegal_o  = r_illegal;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: three variants (default, HALF_EN=0, FWD_EN=0) on shared stimulus,
// directed scenarios plus a random stream checked against a behavioural pipeline model.
module tb_pipe_control;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] I_ADD   = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_LW    = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] I_ADDX5 = 32'h00228333;  // add  x6,x5,x2
  localparam logic [31:0] I_ADDI1 = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] I_ADDI2 = 32'h00108113;  // addi x2,x1,1
  localparam logic [31:0] I_LH    = 32'h00009283;  // lh   x5,0(x1)
  localparam logic [31:0] I_FENCE = 32'h0000000F;
  localparam logic [31:0] I_SBAD  = 32'h0000B023;  // store funct3 011

  logic clk = 1'b0, rst_n = 1'b0, iv = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [31:0] instr = '0;
  int n_tests = 0, n_fail = 0;

  ctrl_t [2:0]      d_ex, d_mem, d_wb;
  logic  [2:0]      d_stall, d_ill;
  logic  [2:0][1:0] d_fa, d_fb;

  ctrl_t m_ex [3], m_mem [3], m_wb [3];
  bit    m_ill [3];

  always #5 clk = ~clk;

  pipe_control u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .instr_valid_i(iv), .instr_i(instr), .hold_i(hold),
    .flush_i(flush), .stall_o(d_stall[0]), .ex_ctrl_o(d_ex[0]), .mem_ctrl_o(d_mem[0]),
    .wb_ctrl_o(d_wb[0]), .fwd_a_o(d_fa[0]), .fwd_b_o(d_fb[0]), .illegal_o(d_ill[0]));
  pipe_control #(.HALF_EN(1'b0)) u_nohalf (
    .clk_i(clk), .rst_n_i(rst_n), .instr_valid_i(iv), .instr_i(instr), .hold_i(hold),
    .flush_i(flush), .stall_o(d_stall[1]), .ex_ctrl_o(d_ex[1]), .mem_ctrl_o(d_mem[1]),
    .wb_ctrl_o(d_wb[1]), .fwd_a_o(d_fa[1]), .fwd_b_o(d_fb[1]), .illegal_o(d_ill[1]));
  pipe_control #(.FWD_EN(1'b0)) u_nofwd (
    .clk_i(clk), .rst_n_i(rst_n), .instr_valid_i(iv), .instr_i(instr), .hold_i(hold),
    .flush_i(flush), .stall_o(d_stall[2]), .ex_ctrl_o(d_ex[2]), .mem_ctrl_o(d_mem[2]),
    .wb_ctrl_o(d_wb[2]), .fwd_a_o(d_fa[2]), .fwd_b_o(d_fb[2]), .illegal_o(d_ill[2]));

  function automatic bit v_half(int v); return v != 1; endfunction
  function automatic bit v_fwd(int v);  return v != 2; endfunction

  function automatic bit ref_ill(logic [31:0] ins, bit half);
    logic [2:0] f;
    f = ins[14:12];
    case (ins[6:0])
      OP_LOAD:  return !(f == 3'd0 || f == 3'd2 || (half && (f == 3'd1 || f == 3'd4 || f == 3'd5)));
      OP_STORE: return !(f == 3'd0 || f == 3'd2 || (half && f == 3'd1));
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: return 1'b0;
      default:  return 1'b1;
    endcase
  endfunction

  function automatic ctrl_t ref_dec(logic [31:0] ins, bit half);
    ctrl_t c;
    alu_t tab [8];
    logic [2:0] f;
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    c = '0;
    f = ins[14:12];
    if (ref_ill(ins, half)) return c;
    c.valid = 1'b1;
    case (ins[6:0])
      OP_OP: begin
        c.regWrite = 1; c.useRs1 = 1; c.useRs2 = 1; c.aluCtrl = tab[f];
        if (ins[30] && f == 3'd0) c.aluCtrl = ALU_SUB;
        if (ins[30] && f == 3'd5) c.aluCtrl = ALU_SRA;
      end
      OP_IMM: begin
        c.regWrite = 1; c.useRs1 = 1; c.aluSrc = 1; c.immSrc = IMM_I; c.aluCtrl = tab[f];
        if (ins[30] && f == 3'd5) c.aluCtrl = ALU_SRA;
      end
      OP_LOAD: begin
        c.regWrite = 1; c.resultSrc = RES_MEM; c.useRs1 = 1; c.aluSrc = 1; c.immSrc = IMM_I;
        c.aluCtrl = ALU_MEMADD; c.memSize = f[1:0]; c.memUnsigned = f[2];
      end
      OP_STORE: begin
        c.memWrite = 1; c.useRs1 = 1; c.useRs2 = 1; c.aluSrc = 1; c.immSrc = IMM_S;
        c.aluCtrl = ALU_MEMADD; c.memSize = f[1:0];
      end
      OP_BRANCH: begin
        c.branch = 1; c.useRs1 = 1; c.useRs2 = 1; c.immSrc = IMM_B;
        if (f >= 3'd6)      c.aluCtrl = ALU_SLTU;
        else if (f >= 3'd4) c.aluCtrl = ALU_SLT;
        else                c.aluCtrl = ALU_SUB;
      end
      OP_JAL: begin
        c.jal = 1; c.regWrite = 1; c.resultSrc = RES_PC4; c.aluSrcA = 1; c.aluSrc = 1;
        c.immSrc = IMM_J; c.aluCtrl = ALU_JAL;
      end
      OP_JALR: begin
        c.jalr = 1; c.regWrite = 1; c.resultSrc = RES_PC4; c.useRs1 = 1; c.aluSrc = 1;
        c.immSrc = IMM_I; c.aluCtrl = ALU_JALR;
      end
      OP_LUI: begin
        c.regWrite = 1; c.aluSrc = 1; c.immSrc = IMM_U; c.aluCtrl = ALU_PASSB;
      end
      default: begin
        c.regWrite = 1; c.aluSrcA = 1; c.aluSrc = 1; c.immSrc = IMM_U; c.aluCtrl = ALU_ADD;
      end
    endcase
    if (c.regWrite) c.rd  = ins[11:7];
    if (c.useRs1)   c.rs1 = ins[19:15];
    if (c.useRs2)   c.rs2 = ins[24:20];
    return c;
  endfunction

  // Does the current ID instruction (as seen by variant v) read register r?
  function automatic bit reads(int v, logic [4:0] r);
    ctrl_t d;
    d = ref_dec(instr, v_half(v));
    return iv && d.valid && r != 5'd0 &&
           ((d.useRs1 && instr[19:15] == r) || (d.useRs2 && instr[24:20] == r));
  endfunction

  function automatic bit m_hz(int v);
    bit lu, raw;
    lu  = m_ex[v].valid && m_ex[v].resultSrc == RES_MEM && reads(v, m_ex[v].rd);
    raw = (m_ex[v].regWrite && reads(v, m_ex[v].rd)) || (m_mem[v].regWrite && reads(v, m_mem[v].rd));
    return lu || (!v_fwd(v) && raw);
  endfunction

  function automatic logic [1:0] m_fwd(int v, logic [4:0] src);
    if (!v_fwd(v)) return 2'b00;
    if (m_mem[v].regWrite && m_mem[v].rd != 5'd0 && m_mem[v].rd == src) return 2'b10;
    if (m_wb[v].regWrite && m_wb[v].rd != 5'd0 && m_wb[v].rd == src)    return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [9];
    int k;
    ops = '{OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    k = $urandom_range(0, 9);
    if (k == 9) return $urandom();
    return {1'b0, 1'($urandom_range(0, 1)), 5'b0, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ops[k]};
  endfunction

  task automatic model_clear();
    for (int v = 0; v < 3; v++) begin
      m_ex[v] = '0; m_mem[v] = '0; m_wb[v] = '0; m_ill[v] = 1'b0;
    end
  endtask

  task automatic tick();
    bit hz;
    for (int v = 0; v < 3; v++) begin
      hz = m_hz(v);
      if (hold) m_ill[v] = 1'b0;
      else begin
        m_wb[v]  = m_mem[v];
        m_mem[v] = m_ex[v];
        m_ex[v]  = (flush || hz || !iv) ? ctrl_t'('0) : ref_dec(instr, v_half(v));
        m_ill[v] = !flush && !hz && iv && ref_ill(instr, v_half(v));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; iv = 1'b0; hold = 1'b0; flush = 1'b0; instr = '0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int v = 0; v < 3; v++) begin
      n_tests++;
      if ({d_ex[v], d_mem[v], d_wb[v]} !== '0) begin
        n_fail++; $display("FAIL reset_stages v%0d: got %h %h %h want all zero", v, d_ex[v], d_mem[v], d_wb[v]);
      end
      n_tests++;
      if ({d_stall[v], d_fa[v], d_fb[v], d_ill[v]} !== 6'b0) begin
        n_fail++; $display("FAIL reset_flags v%0d: got %b want 000000", v, {d_stall[v], d_fa[v], d_fb[v], d_ill[v]});
      end
    end
  endtask

  task automatic test_alu_pass();
    do_reset();
    iv = 1'b1; instr = I_ADD;
    tick();
    iv = 1'b0; instr = '0;
    n_tests++;
    if (d_ex[0].valid !== 1'b1 || d_ex[0].aluCtrl !== ALU_ADD || d_ex[0].regWrite !== 1'b1 || d_ex[0].rd !== 5'd3) begin
      n_fail++; $display("FAIL alu_ex: got %h want valid add regWrite rd3", d_ex[0]);
    end
    n_tests++;
    if (d_ex[0] !== m_ex[0]) begin n_fail++; $display("FAIL alu_ex_model: got %h want %h", d_ex[0], m_ex[0]); end
    tick();
    n_tests++;
    if (d_mem[0] !== m_mem[0] || d_mem[0].rd !== 5'd3 || d_ex[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL alu_mem: got %h want %h", d_mem[0], m_mem[0]);
    end
    tick();
    n_tests++;
    if (d_wb[0] !== m_wb[0] || d_wb[0].rd !== 5'd3 || d_wb[0].valid !== 1'b1) begin
      n_fail++; $display("FAIL alu_wb: got %h want %h", d_wb[0], m_wb[0]);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    iv = 1'b1; instr = I_LW;
    tick();
    instr = I_ADDX5;
    #1;
    n_tests++;
    if (d_stall[0] !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", d_stall[0]); end
    tick();
    n_tests++;
    if (d_ex[0].valid !== 1'b0 || d_stall[0] !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble: got ex.valid %b stall %b want 0 0", d_ex[0].valid, d_stall[0]);
    end
    tick();
    iv = 1'b0;
    n_tests++;
    if (d_ex[0].rd !== 5'd6 || d_fa[0] !== 2'b01 || d_fb[0] !== 2'b00) begin
      n_fail++; $display("FAIL lu_fwd: got rd %0d fa %b fb %b want 6 01 00", d_ex[0].rd, d_fa[0], d_fb[0]);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    do_reset();
    iv = 1'b1; instr = I_ADDI1;
    tick();
    instr = I_ADDI2;
    #1;
    n_tests++;
    if (d_stall[0] !== 1'b0) begin n_fail++; $display("FAIL raw_nostall: got %b want 0", d_stall[0]); end
    tick();
    n_tests++;
    if (d_fa[0] !== 2'b10 || d_ex[0].rd !== 5'd2) begin
      n_fail++; $display("FAIL raw_fwd: got fa %b rd %0d want 10 2", d_fa[0], d_ex[0].rd);
    end
    do_reset();
    iv = 1'b1; instr = I_ADDI1;
    tick();
    instr = I_ADDI2;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (d_stall[2] === 1'b1) begin cnt++; tick(); end
      else break;
    end
    n_tests++;
    if (cnt != 2) begin n_fail++; $display("FAIL nofwd_stall_cycles: got %0d want 2", cnt); end
    tick();
    iv = 1'b0;
    n_tests++;
    if (d_ex[2].rd !== 5'd2 || d_ex[2].valid !== 1'b1 || d_fa[2] !== 2'b00) begin
      n_fail++; $display("FAIL nofwd_ex: got %h want addi x2 with fa 00", d_ex[2]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    iv = 1'b1; instr = I_LW;
    tick();
    instr = I_ADDX5; flush = 1'b1;
    #1;
    n_tests++;
    if (d_stall[0] !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", d_stall[0]); end
    tick();
    flush = 1'b0; iv = 1'b0;
    n_tests++;
    if (d_ex[0].valid !== 1'b0 || d_mem[0].rd !== 5'd5 || d_mem[0].resultSrc !== RES_MEM || d_mem[0] !== m_mem[0]) begin
      n_fail++; $display("FAIL flush_adv: got ex %h mem %h want bubble / lw", d_ex[0], d_mem[0]);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    iv = 1'b1; instr = I_LH;
    tick();
    iv = 1'b0;
    n_tests++;
    if (d_ill[1] !== 1'b1 || d_ex[1].valid !== 1'b0) begin
      n_fail++; $display("FAIL lh_nohalf: got ill %b valid %b want 1 0", d_ill[1], d_ex[1].valid);
    end
    n_tests++;
    if (d_ill[0] !== 1'b0 || d_ex[0].memSize !== MEM_H || d_ex[0].memUnsigned !== 1'b0 || d_ex[0].valid !== 1'b1) begin
      n_fail++; $display("FAIL lh_half: got %h want valid half signed load", d_ex[0]);
    end
    tick();
    n_tests++;
    if (d_ill[1] !== 1'b0) begin n_fail++; $display("FAIL ill_pulse: got %b want 0", d_ill[1]); end
    iv = 1'b1; instr = I_FENCE;
    tick();
    n_tests++;
    if (d_ill[0] !== 1'b1 || d_ex[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL ill_opcode: got ill %b valid %b want 1 0", d_ill[0], d_ex[0].valid);
    end
    instr = I_SBAD;
    tick();
    iv = 1'b0;
    n_tests++;
    if (d_ill[0] !== 1'b1 || d_ex[0] !== '0) begin
      n_fail++; $display("FAIL ill_store: got ill %b ex %h want 1 bubble", d_ill[0], d_ex[0]);
    end
  endtask

  task automatic test_hold();
    ctrl_t s_ex, s_mem, s_wb;
    do_reset();
    iv = 1'b1;
    instr = I_ADDI1; tick();
    instr = I_ADD;   tick();
    instr = I_LW;    tick();
    s_ex = d_ex[0]; s_mem = d_mem[0]; s_wb = d_wb[0];
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = gen_instr();
      tick();
      n_tests++;
      if (d_ex[0] !== s_ex || d_mem[0] !== s_mem || d_wb[0] !== s_wb || d_ill[0] !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d: got %h %h %h want %h %h %h", i, d_ex[0], d_mem[0], d_wb[0], s_ex, s_mem, s_wb);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int v = 0; v < 3; v++) begin
      n_tests++;
      if ({d_ex[v], d_mem[v], d_wb[v]} !== '0 || d_ill[v] !== 1'b0) begin
        n_fail++; $display("FAIL async_reset v%0d: got %h %h %h want all zero", v, d_ex[v], d_mem[v], d_wb[v]);
      end
    end
    hold = 1'b0; iv = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      instr = gen_instr();
      iv    = ($urandom_range(0, 7) != 0);
      hold  = ($urandom_range(0, 15) == 0);
      flush = ($urandom_range(0, 11) == 0);
      #1;
      for (int v = 0; v < 3; v++) begin
        n_tests++;
        if (d_stall[v] !== (m_hz(v) && !flush) || d_fa[v] !== m_fwd(v, m_ex[v].rs1) || d_fb[v] !== m_fwd(v, m_ex[v].rs2)) begin
          n_fail++; $display("FAIL rand_comb c%0d v%0d: got %b %b %b want %b %b %b", c, v, d_stall[v], d_fa[v], d_fb[v],
                             m_hz(v) && !flush, m_fwd(v, m_ex[v].rs1), m_fwd(v, m_ex[v].rs2));
        end
      end
      tick();
      for (int v = 0; v < 3; v++) begin
        n_tests++;
        if (d_ex[v] !== m_ex[v] || d_mem[v] !== m_mem[v] || d_wb[v] !== m_wb[v] || d_ill[v] !== m_ill[v]) begin
          n_fail++; $display("FAIL rand_regs c%0d v%0d: got %h %h %h %b want %h %h %h %b", c, v, d_ex[v], d_mem[v],
                             d_wb[v], d_ill[v], m_ex[v], m_mem[v], m_wb[v], m_ill[v]);
        end
      end
    end
    iv = 1'b0; hold = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined successor to the single-cycle control decoder. Decodes the ID-stage instruction into a control bundle and carries it through ID→EX→MEM→WB pipeline registers. Performs load-use hazard detection and EX-stage operand forwarding selection, and handles stall and flush. Sits between the IF/ID register and the datapath of the 5-stage RV32I core.

## Interface
- `HALF_EN`, default 1: 1 = lh/lhu/lbu/sh decoded as legal; 0 = those encodings are illegal.
- `FWD_EN`, default 1: 1 = forwarding; 0 = `fwd_*_o` tied 00 and RAW hazards stall.
- `REG_ADDR_W`, default 5: register index width (4 for RV32E).
- `clk_i`, input, 1: clock; single clock domain.
- `rst_n_i`, input, 1: reset; asynchronous, active-low.
- `instr_valid_i`, input, 1: IF/ID register holds a real instruction.
- `instr_i`, input, 32: ID-stage instruction.
- `hold_i`, input, 1: external freeze (memory not ready); all stage registers keep their value.
- `flush_i`, input, 1: branch/jump resolved taken in EX; kill the ID instruction.
- `stall_o`, output, 1: hold PC and IF/ID (hazard bubble inserted).
- `ex_ctrl_o`, `mem_ctrl_o`, `wb_ctrl_o`, output, `ctrl_t`: per-stage control bundles.
- `fwd_a_o`, `fwd_b_o`, output, 2: EX operand source. 00 = regfile, 10 = MEM ALU result, 01 = WB result.
- `illegal_o`, output, 1: the instruction captured into EX this cycle was illegal.

## Operation
`ctrl_t` fields:
- `valid`, `regWrite`, `memWrite`
- `resultSrc[1:0]`: 00 = ALU, 01 = memory, 10 = PC+4
- `aluCtrl[3:0]`, `aluSrcA` (1 = PC), `aluSrc` (1 = imm), `immSrc[2:0]`
- `branch`, `jal`, `jalr`
- `memSize[1:0]`: 00 = byte, 01 = half, 10 = word
- `memUnsigned`
- `rd`, `rs1`, `rs2`
- `useRs1`, `useRs2`

ALU codes:
- add 0000, sub 0001, and 0010, or 0011, xor 0100
- slt 0101, sltu 0110, srl 0111, sll 1000, sra 1001
- passB 1010, jalr 1011, jal 1100, mem-add 1111

ImmSrc codes: I 000, S 001, B 010, U 011, J 100.

Decode rules:
- R-type: funct3 plus bit 30 select add/sub and srl/sra.
- OP-IMM, funct3 000: always add; bit 30 is ignored.
- OP-IMM, funct3 101: bit 30 selects srai/srli.
- lui: passB, U-imm.
- auipc: add, `aluSrcA` = 1, U-imm.
- jal/jalr: `resultSrc` = 10, `regWrite` = 1.
- Branches: `branch` = 1; funct3 is carried in `aluCtrl` via sub/slt/sltu; the branch unit uses funct3 from its own pipe.

Illegal instruction:
- Triggers: unknown opcode; load funct3 ∉ {000, 001, 010, 100, 101}; store funct3 ∉ {000, 001, 010}; half/unsigned variants when `HALF_EN` = 0.
- Effect: the instruction enters EX as a bubble and `illegal_o` pulses.

Hazards:
- Load-use: EX holds a valid load with `rd` ≠ 0, and `rd` matches an ID source that is used.
  - `stall_o` = 1 and `ex_q` ← bubble.
- With `FWD_EN` = 0, a match against any `regWrite` EX or MEM `rd` ≠ 0 also stalls.
- The regfile is write-before-read, so WB never stalls.

Forwarding (`FWD_EN` = 1):
- `fwd_a_o` = 10 if MEM `regWrite` and `rd` ≠ 0 and `rd` == EX `rs1`.
- Otherwise 01 if the same conditions hold for WB.
- Otherwise 00.
- MEM takes priority over WB. `fwd_b_o` follows the same rules on `rs2`.

Bubble: all-zero `ctrl_t`.

## Timing
Reset (asynchronous): all three stage registers hold a bubble. `stall_o` = 0, `fwd_*_o` = 00, `illegal_o` = 0.

Latency:
- Decode is combinational in ID.
- The bundle appears on `ex_ctrl_o` 1 cycle after the ID cycle, `mem_ctrl_o` after 2, `wb_ctrl_o` after 3.
- `fwd_*_o` and `stall_o` are combinational from the current stage registers and ID.

Per-edge priority, highest first:
1. `hold_i`: every register keeps its value. `stall_o` is still driven. `illegal_o` = 0.
2. `flush_i`: `ex_q` ← bubble. MEM/WB advance. `stall_o` is forced to 0; flush wins over load-use.
3. Hazard stall: `ex_q` ← bubble. MEM/WB advance. ID is held upstream.
4. Normal: `ex_q` ← decode (a bubble if `!instr_valid_i`), `mem_q` ← `ex_q`, `wb_q` ← `mem_q`.

Reset asserted mid-operation: registers clear immediately, without waiting for a clock edge.

## Structure
- `pipe_ctrl_pkg`: `ctrl_t`, opcode constants, ALU codes, ImmSrc codes, resultSrc codes.
- Sub-module `pipe_decode`: purely combinational `instr` → `ctrl_t` plus illegal flag, parametrised by `HALF_EN`.
- `pipe_control` holds the three stage registers, hazard logic and forwarding logic.

## Test plan
- **Reset and ALU pass-through:** reset, then `add x3,x1,x2` (0x002081B3) valid.
  - Next cycle: `ex_ctrl_o` valid, `aluCtrl` 0000, `regWrite` 1, `rd` 3.
  - Then `mem_ctrl_o`, then `wb_ctrl_o`.
- **Load-use:** `lw x5,0(x1)` followed by `add x6,x5,x2`.
  - One cycle with `stall_o` = 1 and an EX bubble.
  - Then add in EX with `fwd_a_o` = 01.
- **Back-to-back RAW:** `addi x1,x0,1`; `addi x2,x1,1`.
  - `fwd_a_o` = 10 while the second instruction is in EX.
  - `FWD_EN` = 0: `stall_o` high for 2 cycles.
- **Flush:** `flush_i` asserted in the same cycle as a load-use hazard.
  - `stall_o` = 0, `ex_ctrl_o` becomes a bubble, MEM advances.
- **Illegal and HALF_EN:**
  - `HALF_EN` = 0 with `lh` (funct3 001) → `illegal_o` = 1 for one cycle, `ex_ctrl_o.valid` = 0.
  - `HALF_EN` = 1 → `memSize` 01, `memUnsigned` 0.
- **Hold:** `hold_i` for 3 cycles mid-stream → all `*_ctrl_o` stable. Async reset during hold → all bubbles immediately.
